// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

endpackage : stream_demux_pkg

// File: rtl/demux_slot.sv
// One-entry holding slot for a single output channel of stream_demux.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  slot_state_e           state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  drain_c;

  assign drain_c = (state_q == SLOT_FULL) & ready_i;

  // Occupancy: a load always leaves the slot full, even when draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
    end else begin
      case (state_q)
        SLOT_EMPTY: if (load_i) state_q <= SLOT_FULL;
        SLOT_FULL:  if (drain_c && !load_i) state_q <= SLOT_EMPTY;
        default:    state_q <= SLOT_EMPTY;
      endcase
    end
  end

  // Payload is qualified by state, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (load_i) data_q <= data_i;
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule : demux_slot

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer with per-channel holding slots.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned NUM_OUT    = 2,
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned SEL_W      = $clog2(NUM_OUT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]      in_sel_i,
  output logic [NUM_OUT-1:0]    out_valid_o,
  input  logic [NUM_OUT-1:0]    out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o [NUM_OUT-1:0],
  output logic                  drop_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  logic [NUM_OUT-1:0]    slot_valid;
  logic [NUM_OUT-1:0]    load_c;
  logic                  sel_ready_c;
  logic                  sel_hit_c;
  logic                  accept_c;
  logic                  drop_c;
  logic                  drop_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Ready mux over the selected slot; out-of-range selects are always taken.
  always_comb begin
    sel_ready_c = 1'b1;
    sel_hit_c   = 1'b0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (in_sel_i == SEL_W'(k)) begin
        sel_hit_c   = 1'b1;
        sel_ready_c = ~slot_valid[k] | out_ready_i[k];
      end
    end
  end

  assign in_ready_o = sel_ready_c;
  assign accept_c   = in_valid_i & sel_ready_c;
  assign drop_c     = accept_c & ~sel_hit_c;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    assign load_c[g] = accept_c & (in_sel_i == SEL_W'(g));

    demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_c[g]),
      .data_i  (in_data_i),
      .ready_i (out_ready_i[g]),
      .valid_o (slot_valid[g]),
      .data_o  (out_data_o[g])
    );
  end

  // Discard reporting: one-cycle pulse plus saturating tally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= drop_c;
      if (drop_c && (drop_cnt_q != DROP_CNT_MAX)) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  assign out_valid_o = slot_valid;
  assign drop_o      = drop_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux with three channels (select 3 is out of range).
module tb_stream_demux;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data [N-1:0];
  logic          drop;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [N-1:0][$];
  int            drop_pend = 0;
  bit            mon_en    = 1'b0;
  bit            rand_rdy  = 1'b0;

  stream_demux #(
    .NUM_OUT    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .drop_o      (drop),
    .drop_cnt_o  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented beat must match the head of its channel queue.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int k = 0; k < int'(N); k++) begin
        if (out_valid[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, out_data[k]);
          end else begin
            if (out_data[k] !== exp_q[k][0]) begin
              errors++;
              $display("FAIL beat_data ch%0d: got %0h expected %0h", k, out_data[k], exp_q[k][0]);
            end
            if (out_ready[k]) void'(exp_q[k].pop_front());
          end
        end
      end
      if (drop) begin
        checks++;
        if (drop_pend == 0) begin
          errors++;
          $display("FAIL drop_pulse: got 1 expected 0");
        end else begin
          drop_pend--;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = N'($urandom);
    end
  end

  // Drive one beat and hold it until accepted; scoreboard entry pushed at accept.
  task automatic send(input logic [1:0] sel, input logic [DW-1:0] d, output int waited);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel < 2'(N)) exp_q[sel].push_back(d);
        else             drop_pend++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got stalled expected accept sel=%0d", sel);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int wsum;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '1;
    rst_n     = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    idle(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // Streaming: back-to-back to every channel, one cycle each, visible next cycle.
    wsum = 0;
    for (int i = 0; i < int'(N); i++) begin
      send(2'(i), 8'(8'h11 + i), w);
      wsum += w;
      chk("stream_valid", 32'(out_valid[i]), 32'h1);
      chk("stream_data", 32'(out_data[i]), 32'(8'h11 + i));
    end
    chk("stream_no_stall", 32'(wsum), 32'h0);
    idle(2);

    // Backpressure isolation on channel 2.
    out_ready = 3'b011;
    send(2'd2, 8'hA5, w);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 8'h3C;
    repeat (2) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(in_ready), 32'h0);
      chk("bp_hold", 32'(out_data[2]), 32'hA5);
      @(posedge clk);
      #1;
    end
    send(2'd0, 8'h77, w);
    chk("bp_other_nowait", 32'(w), 32'h0);
    chk("bp_other_valid", 32'(out_valid[0]), 32'h1);
    chk("bp_other_data", 32'(out_data[0]), 32'h77);
    out_ready = '1;
    idle(2);

    // Simultaneous drain and load on channel 1.
    out_ready = 3'b101;
    send(2'd1, 8'h01, w);
    out_ready = '1;
    send(2'd1, 8'h02, w);
    chk("sim_nowait", 32'(w), 32'h0);
    chk("sim_valid", 32'(out_valid[1]), 32'h1);
    chk("sim_data", 32'(out_data[1]), 32'h02);
    idle(2);

    // Out-of-range select is swallowed and counted, saturating at 255.
    send(2'd3, 8'hFF, w);
    chk("oor_nowait", 32'(w), 32'h0);
    chk("oor_no_valid", 32'(out_valid), 32'h0);
    chk("oor_drop_pulse", 32'(drop), 32'h1);
    chk("oor_cnt1", 32'(drop_cnt), 32'h1);
    idle(1);
    chk("oor_pulse_once", 32'(drop), 32'h0);
    for (int i = 0; i < 300; i++) send(2'd3, 8'hFF, w);
    idle(2);
    chk("oor_saturate", 32'(drop_cnt), 32'd255);

    // Random soak with random per-channel backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), w);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = '1;
    idle(4);
    for (int k = 0; k < int'(N); k++) chk("soak_drained", 32'(exp_q[k].size()), 32'h0);
    chk("soak_drops_seen", 32'(drop_pend), 32'h0);
    chk("soak_cnt_sat", 32'(drop_cnt), 32'd255);

    // Asynchronous reset with channel 1 full.
    out_ready = 3'b101;
    send(2'd1, 8'h55, w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_cnt", 32'(drop_cnt), 32'h0);
    chk("arst_drop", 32'(drop), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < int'(N); k++) exp_q[k].delete();
    drop_pend = 0;
    out_ready = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(2'd1, 8'h66, w);
    chk("post_rst_nowait", 32'(w), 32'h0);
    chk("post_rst_data", 32'(out_data[1]), 32'h66);
    idle(3);
    for (int k = 0; k < int'(N); k++) chk("final_drained", 32'(exp_q[k].size()), 32'h0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_demux

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-NUM_OUT stream demultiplexer: the inverse of the N-input select mux. Accepts one valid/ready input beat carrying data and a select index, and delivers it on the selected output channel through a one-entry holding slot per channel. It sits at the fan-out side of a datapath, after a single producer that feeds several independent consumers. Full throughput when consumers keep up; per-channel backpressure never blocks beats bound for other channels.

## Interface
- NUM_OUT, 2: number of output channels; legal range 2..16.
- DATA_WIDTH, 8: data beat width.
- SEL_W, $clog2(NUM_OUT): derived select width; not overridden.
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted this cycle when high with in_valid_i.
- in_data_i  input  DATA_WIDTH  input beat data.
- in_sel_i  input  SEL_W  destination channel index.
- out_valid_o  output  NUM_OUT  per-channel valid.
- out_ready_i  input  NUM_OUT  per-channel ready.
- out_data_o  output  DATA_WIDTH x NUM_OUT (unpacked array [NUM_OUT-1:0])  per-channel data.
- drop_o  output  1  one-cycle pulse: an out-of-range beat was discarded.
- drop_cnt_o  output  8  saturating count of discarded beats.

## Operation
- Each channel k owns a slot with 2-state FSM: EMPTY -> FULL on load; FULL -> EMPTY on drain without load; FULL stays FULL on simultaneous drain and load.
- load[k] = in_valid_i & in_ready_o & (in_sel_i == k); drain[k] = out_valid_o[k] & out_ready_i[k].
- in_ready_o = 1 when in_sel_i >= NUM_OUT; otherwise in_ready_o = (slot[in_sel_i] EMPTY) | out_ready_i[in_sel_i].
- in_ready_o may depend combinationally on in_sel_i and out_ready_i; it does not depend on in_valid_i.
- out_valid_o[k] = slot k FULL; out_data_o[k] = slot k register, stable while valid and not ready.
- Out-of-range select (only possible when NUM_OUT is not a power of 2): beat accepted and discarded, no slot changes, drop_o pulses the next cycle, drop_cnt_o increments and saturates at 255.
- Channels are independent: any number of channels may drain in the same cycle as one load.
- Slot data registers load only on load[k]; no reset needed on data.

## Timing
- Latency: beat accepted on edge N appears on out_valid_o/out_data_o after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle to one channel when its consumer holds ready high; 1 beat/cycle total across channels.
- Reset (rst_ni low, asynchronous): all slots EMPTY, out_valid_o = 0, drop_o = 0, drop_cnt_o = 0. in_ready_o is 1 during reset, but no beat is accepted while rst_ni is low.
- Reset mid-operation: held beats are lost; no partial output; first accept is legal on the first edge after rst_ni rises.
- Full slot, consumer stalled: beats to that channel stall (in_ready_o = 0); beats to other channels are unaffected.
- Full slot, consumer ready in the same cycle: new beat accepted, old beat handed off, and the slot holds the new beat next cycle.

## Structure
- Package stream_demux_pkg: slot_state_e enum {SLOT_EMPTY, SLOT_FULL}, DROP_CNT_W = 8 localparam, DROP_CNT_MAX constant.
- Sub-module demux_slot: one-entry register slice with load/drain, FSM, data register, valid_o. Instantiated NUM_OUT times through a generate loop.
- Top contains select decode, in_ready_o mux, drop pulse and counter.

## Test plan
- Reset: assert rst_ni low mid-transfer with channel 1 FULL -> out_valid_o = 0 and drop_cnt_o = 0 immediately (asynchronous), before the next edge.
- Streaming: NUM_OUT=4, all ready=1, send 0x11..0x14 to sel 0,1,2,3 on consecutive cycles -> each appears on its channel exactly one cycle after accept, in_ready_o constantly 1.
- Backpressure isolation: out_ready_i[2] = 0, send 0xA5 to ch2 then 0x3C to ch2 then 0x77 to ch0 -> first accepted, second stalls (in_ready_o = 0, 0xA5 held stable), then after sel changes to 0, 0x77 is accepted and appears on ch0 next cycle.
- Simultaneous drain/load: ch1 FULL with 0x01 and ready=1, send 0x02 to ch1 -> accepted same cycle, ch1 shows 0x02 next cycle, no bubble.
- Out-of-range: NUM_OUT=3, send 0xFF with sel=3 -> in_ready_o = 1, no out_valid_o asserted, drop_o pulses once, drop_cnt_o = 1. Send 300 such beats -> drop_cnt_o = 255.
- Random soak: 2000 random beats/sel/ready -> scoreboard per-channel FIFO order matches, no loss, no duplication.
